vga_image_scanner: RTL and testbench

//  Read-side initiator for the image ROM: generates 640x480@60 VGA timing from the 25 MHz pixel clock.

---
 rtl/vga_pkg.sv | 55 +++++
 rtl/vga_timing_gen.sv | 64 ++++++
 rtl/vga_image_scanner.sv | 152 +++++++++++++++
 tb/tb_vga_image_scanner.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour/output types and small helpers used by
// the image scanner and its timing generator.
package vga_pkg;

    // 640x480@60 timing, pixels per line / lines per frame
    localparam int H_ACTIVE     = 32'd640;
    localparam int H_FP         = 32'd16;
    localparam int H_SYNC       = 32'd96;
    localparam int H_BP         = 32'd48;
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_ACTIVE     = 32'd480;
    localparam int V_FP         = 32'd10;
    localparam int V_SYNC       = 32'd2;
    localparam int V_BP         = 32'd33;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        rgb_t rgb;
        logic hsync;
        logic vsync;
        logic blank_n;
    } vga_out_t;

    // Pin state while in reset: black, syncs idle high, blanked
    localparam vga_out_t VGA_OUT_RST = '{
        rgb:     '{r: 8'h00, g: 8'h00, b: 8'h00},
        hsync:   1'b1,
        vsync:   1'b1,
        blank_n: 1'b0
    };

    // Split a packed {R,G,B} word into its channels
    function automatic rgb_t to_rgb(input logic [23:0] c);
        return '{r: c[23:16], g: c[15:8], b: c[7:0]};
    endfunction

    // Half-open window test lo <= x < hi
    function automatic logic in_window(input logic [31:0] x,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running horizontal/vertical raster counters with the active-region,
// sync and start-of-frame flags decoded from the current counter values.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int HW       = $clog2(vga_pkg::H_TOTAL),
    parameter int VW       = $clog2(vga_pkg::V_TOTAL)
) (
    input  logic          clk_25M,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          sof
);
    import vga_pkg::*;

    localparam logic [HW-1:0] H_LAST_C  = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG_C  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END_C  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ONE_C   = HW'(1);
    localparam logic [VW-1:0] V_LAST_C  = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG_C  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END_C  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ONE_C   = VW'(1);

    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;

    // Raster position: pixel counter wraps at end of line and steps the line counter
    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (h_cnt_r == H_LAST_C) begin
            h_cnt_r <= '0;
            if (v_cnt_r == V_LAST_C) begin
                v_cnt_r <= '0;
            end else begin
                v_cnt_r <= v_cnt_r + V_ONE_C;
            end
        end else begin
            h_cnt_r <= h_cnt_r + H_ONE_C;
        end
    end

    assign h_cnt  = h_cnt_r;
    assign v_cnt  = v_cnt_r;
    assign active = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
    assign hsync  = !((h_cnt_r >= HS_BEG_C) && (h_cnt_r < HS_END_C));
    assign vsync  = !((v_cnt_r >= VS_BEG_C) && (v_cnt_r < VS_END_C));
    assign sof    = (h_cnt_r == '0) && (v_cnt_r == '0);

endmodule

// File: rtl/vga_image_scanner.sv
// Reads a stored picture from a combinational ROM in raster order and drives
// the VGA pins. Counters -> ROM address (stage 1) -> registered pins (stage 2);
// every pin carries the same two-cycle latency so colour and syncs never skew.
module vga_image_scanner #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int IMG_W    = 32'd200,
    parameter int IMG_H    = 32'd200,
    parameter int IMG_X0   = 32'd220,
    parameter int IMG_Y0   = 32'd140,
    parameter int width    = 32'd24,
    parameter int addrSize = 32'd16,
    parameter logic [width-1:0] BG_COLOUR = 24'h000000
) (
    input  logic                clk_25M,
    input  logic                reset,
    output logic [addrSize-1:0] image_addr,
    input  logic [width-1:0]    colour_data,
    output logic [7:0]          vga_r,
    output logic [7:0]          vga_g,
    output logic [7:0]          vga_b,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic                vga_blank_n,
    output logic                frame_start
);
    import vga_pkg::*;

    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    localparam logic [31:0] X_LO = 32'(IMG_X0);
    localparam logic [31:0] X_HI = 32'(IMG_X0 + IMG_W);
    localparam logic [31:0] Y_LO = 32'(IMG_Y0);
    localparam logic [31:0] Y_HI = 32'(IMG_Y0 + IMG_H);
    localparam logic [addrSize-1:0] ADDR_ONE = addrSize'(1);

    if (IMG_W * IMG_H > 2 ** addrSize) begin : g_addr_chk
        $error("vga_image_scanner: IMG_W*IMG_H does not fit in addrSize address bits");
    end
    if (width != 24) begin : g_width_chk
        $error("vga_image_scanner: colour word must be 24 bits {R,G,B}");
    end

    logic [HW-1:0]       h_cnt_s;
    logic [VW-1:0]       v_cnt_s;
    logic                active_s;
    logic                hsync_s;
    logic                vsync_s;
    logic                sof_s;
    logic                in_img_s;
    logic [addrSize-1:0] addr_base_s;

    logic [addrSize-1:0] addr_cnt_r;
    logic [addrSize-1:0] image_addr_r;
    logic                in_img_d1_r;
    logic                active_d1_r;
    logic                hsync_d1_r;
    logic                vsync_d1_r;
    logic                sof_d1_r;
    vga_out_t            out_r;
    logic                frame_start_r;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HW       (HW),       .VW   (VW)
    ) u_timing (
        .clk_25M (clk_25M),
        .reset   (reset),
        .h_cnt   (h_cnt_s),
        .v_cnt   (v_cnt_s),
        .active  (active_s),
        .hsync   (hsync_s),
        .vsync   (vsync_s),
        .sof     (sof_s)
    );

    // Clipping falls out of qualifying the picture window with the active region
    assign in_img_s = active_s
                    && in_window(32'(h_cnt_s), X_LO, X_HI)
                    && in_window(32'(v_cnt_s), Y_LO, Y_HI);

    // Address restarts at the first pixel of every frame, even if the picture sits at (0,0)
    assign addr_base_s = sof_s ? '0 : addr_cnt_r;

    // Running picture address: advances once per visible picture pixel, no multiply
    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            addr_cnt_r <= '0;
        end else if (in_img_s) begin
            addr_cnt_r <= addr_base_s + ADDR_ONE;
        end else begin
            addr_cnt_r <= addr_base_s;
        end
    end

    // Stage 1: present the ROM address and carry the pixel's flags alongside it
    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            image_addr_r <= '0;
            in_img_d1_r  <= 1'b0;
            active_d1_r  <= 1'b0;
            hsync_d1_r   <= 1'b1;
            vsync_d1_r   <= 1'b1;
            sof_d1_r     <= 1'b0;
        end else begin
            image_addr_r <= in_img_s ? addr_base_s : '0;
            in_img_d1_r  <= in_img_s;
            active_d1_r  <= active_s;
            hsync_d1_r   <= hsync_s;
            vsync_d1_r   <= vsync_s;
            sof_d1_r     <= sof_s;
        end
    end

    // Stage 2: pick ROM data, background or black and register all pins together
    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            out_r         <= VGA_OUT_RST;
            frame_start_r <= 1'b0;
        end else begin
            if (!active_d1_r) begin
                out_r.rgb <= VGA_OUT_RST.rgb;
            end else if (in_img_d1_r) begin
                out_r.rgb <= to_rgb(colour_data[23:0]);
            end else begin
                out_r.rgb <= to_rgb(BG_COLOUR[23:0]);
            end
            out_r.hsync   <= hsync_d1_r;
            out_r.vsync   <= vsync_d1_r;
            out_r.blank_n <= active_d1_r;
            frame_start_r <= sof_d1_r;
        end
    end

    assign image_addr  = image_addr_r;
    assign vga_r       = out_r.rgb.r;
    assign vga_g       = out_r.rgb.g;
    assign vga_b       = out_r.rgb.b;
    assign vga_hsync   = out_r.hsync;
    assign vga_vsync   = out_r.vsync;
    assign vga_blank_n = out_r.blank_n;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_image_scanner.sv
// Bench for vga_image_scanner using a shrunken raster so whole frames fit in a
// short run. Two instances: one with the picture fully on screen, one with the
// picture overrunning the right and bottom edges. A random-content ROM feeds
// both; expected pins come from raster arithmetic on the pixel index.
module tb_vga_image_scanner;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int MW = 20, MH = 16, MX = 30, MY = 20;
    localparam int CW = 20, CH = 16, CX = 54, CY = 40;
    localparam logic [23:0] BG = 24'h0F1E2D;

    logic        clk_25M = 1'b0;
    logic        reset;
    logic [15:0] m_addr, c_addr;
    logic [23:0] m_col, c_col;
    logic [7:0]  m_r, m_g, m_b, c_r, c_g, c_b;
    logic        m_hs, m_vs, m_bn, m_fs, c_hs, c_vs, c_bn, c_fs;

    logic [23:0] rom [0:511];
    int          clip_idx [0:FR-1];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          hs_low, vs_low, m_max, m_nz, c_max;

    always #20 clk_25M = ~clk_25M;

    assign m_col = rom[m_addr[8:0]];
    assign c_col = rom[c_addr[8:0]];

    vga_image_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(MW), .IMG_H(MH), .IMG_X0(MX), .IMG_Y0(MY),
        .width(24), .addrSize(16), .BG_COLOUR(BG)
    ) u_main (
        .clk_25M(clk_25M), .reset(reset), .image_addr(m_addr), .colour_data(m_col),
        .vga_r(m_r), .vga_g(m_g), .vga_b(m_b), .vga_hsync(m_hs), .vga_vsync(m_vs),
        .vga_blank_n(m_bn), .frame_start(m_fs)
    );

    vga_image_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(CW), .IMG_H(CH), .IMG_X0(CX), .IMG_Y0(CY),
        .width(24), .addrSize(16), .BG_COLOUR(BG)
    ) u_clip (
        .clk_25M(clk_25M), .reset(reset), .image_addr(c_addr), .colour_data(c_col),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b), .vga_hsync(c_hs), .vga_vsync(c_vs),
        .vga_blank_n(c_bn), .frame_start(c_fs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic on_screen(input int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    function automatic logic main_in(input int p);
        int h = p % HT;
        int v = p / HT;
        return on_screen(p) && h >= MX && h < MX + MW && v >= MY && v < MY + MH;
    endfunction

    function automatic int main_idx(input int p);
        return ((p / HT) - MY) * MW + ((p % HT) - MX);
    endfunction

    task automatic check_pins_reset();
        check("m_rgb_rst", {8'h00, m_r, m_g, m_b}, 32'h0);
        check("m_hs_rst", 32'(m_hs), 32'd1);
        check("m_vs_rst", 32'(m_vs), 32'd1);
        check("m_bn_rst", 32'(m_bn), 32'd0);
        check("m_fs_rst", 32'(m_fs), 32'd0);
        check("c_rgb_rst", {8'h00, c_r, c_g, c_b}, 32'h0);
        check("c_fs_rst", 32'(c_fs), 32'd0);
    endtask

    task automatic check_reset_all();
        check_pins_reset();
        check("m_addr_rst", 32'(m_addr), 32'd0);
        check("c_addr_rst", 32'(c_addr), 32'd0);
    endtask

    // m = number of rising edges since reset release
    task automatic check_cycle(input int m);
        int pa, p, h, v;
        logic act;
        logic [23:0] e_m, e_c;
        if (m == 0) begin
            check("m_addr", 32'(m_addr), 32'd0);
            check("c_addr", 32'(c_addr), 32'd0);
        end else begin
            pa = (m - 1) % FR;
            check("m_addr", 32'(m_addr), main_in(pa) ? 32'(main_idx(pa)) : 32'd0);
            check("c_addr", 32'(c_addr), (clip_idx[pa] >= 0) ? 32'(clip_idx[pa]) : 32'd0);
        end
        if (m < 2) begin
            check_pins_reset();
        end else begin
            p   = (m - 2) % FR;
            h   = p % HT;
            v   = p / HT;
            act = on_screen(p);
            e_m = !act ? 24'h0 : (main_in(p) ? rom[main_idx(p)] : BG);
            e_c = !act ? 24'h0 : ((clip_idx[p] >= 0) ? rom[clip_idx[p]] : BG);
            check("m_rgb", {8'h00, m_r, m_g, m_b}, {8'h00, e_m});
            check("m_hsync", 32'(m_hs), 32'(!(h >= HA + HF && h < HA + HF + HS)));
            check("m_vsync", 32'(m_vs), 32'(!(v >= VA + VF && v < VA + VF + VS)));
            check("m_blank_n", 32'(m_bn), 32'(act));
            check("m_frame_start", 32'(m_fs), 32'(p == 0));
            check("c_rgb", {8'h00, c_r, c_g, c_b}, {8'h00, e_c});
            check("c_blank_n", 32'(c_bn), 32'(act));
            check("c_frame_start", 32'(c_fs), 32'(p == 0));
        end
    endtask

    task automatic run_phase(input int n, input bit agg);
        for (int m = 0; m < n; m++) begin
            if (m > 0) @(negedge clk_25M);
            cyc = m;
            check_cycle(m);
            if (agg && m >= 2 && m < 2 + FR) begin
                if (!m_hs) hs_low++;
                if (!m_vs) vs_low++;
            end
            if (agg && m >= 1 && m < 1 + FR) begin
                if (int'(m_addr) > m_max) m_max = int'(m_addr);
                if (m_addr != 16'd0) m_nz++;
                if (int'(c_addr) > c_max) c_max = int'(c_addr);
            end
        end
    endtask

    initial begin
        int cnt;
        int h, v;
        for (int i = 0; i < 512; i++) rom[i] = 24'($urandom);
        cnt = 0;
        for (int p = 0; p < FR; p++) begin
            h = p % HT;
            v = p / HT;
            if (on_screen(p) && h >= CX && h < CX + CW && v >= CY && v < CY + CH) begin
                clip_idx[p] = cnt;
                cnt++;
            end else begin
                clip_idx[p] = -1;
            end
        end
        hs_low = 0; vs_low = 0; m_max = 0; m_nz = 0; c_max = 0;

        reset = 1'b0;
        repeat (3) @(negedge clk_25M);
        cyc = -1;
        check_reset_all();
        reset = 1'b1;
        run_phase(FR + int'($urandom_range(100, 4000)), 1'b0);

        // Mid-frame reset: pins must drop to reset values at once and stay there
        reset = 1'b0;
        #1;
        cyc = -2;
        check_reset_all();
        repeat (3) begin
            @(negedge clk_25M);
            check_reset_all();
        end
        reset = 1'b1;
        run_phase(2 * FR + 4, 1'b1);

        cyc = -3;
        check("hsync_low_per_frame", 32'(hs_low), 32'(VT * HS));
        check("vsync_low_per_frame", 32'(vs_low), 32'(VS * HT));
        check("main_max_addr", 32'(m_max), 32'(MW * MH - 1));
        check("main_nonzero_fetches", 32'(m_nz), 32'(MW * MH - 1));
        check("clip_max_addr", 32'(c_max), 32'((HA - CX) * (VA - CY) - 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
